alu_serial_responder: RTL and testbench
=======================================

# alu_serial_responder

Bit-serial responder at the ALU end of the processor-to-ALU link. It shifts in one `Isa::AluPacket` bit by bit, op_code first, and executes ADD, AND or OR on the two operands. It then shifts the `REGISTER_SIZE`-bit result back to the processor bit by bit. It is the counterpart of the processor's packet transmitter and sits between the processor serial port and the datapath.

## Interface
Parameters:
- `DATA_WIDTH`, default `Isa::REGISTER_SIZE` (32): operand and result width.
- `OPCODE_WIDTH`, default `$bits(Isa::Operation)` (3): op_code field width.

Ports:
- `clock`, in, 1: single clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `rx_data`, in, 1: incoming packet bit.
- `rx_valid`, in, 1: `rx_data` is valid this cycle.
- `rx_ready`, out, 1: responder accepts a bit this cycle.
- `tx_data`, out, 1: outgoing result bit.
- `tx_valid`, out, 1: `tx_data` is valid this cycle. No backpressure.
- `op_error`, out, 1: current result belongs to an unsupported op_code. Valid while `tx_valid`=1.

## Operation
- Packet length is P = OPCODE_WIDTH + 2·DATA_WIDTH, which is 67 bits.
- Bit order: op_code bits first, then op_1, then op_2, each LSB first.
- A bit is accepted on any rising edge where `rx_valid` && `rx_ready`. Gaps (`rx_valid`=0) are allowed anywhere in a packet and do not reset the bit count.
- FSM states:
  - IDLE: `rx_ready`=1. The first accepted bit moves the FSM to RECV, and that bit counts as bit 0.
  - RECV: `rx_ready`=1. A 7-bit counter counts accepted bits. Accepting bit P−1 moves the FSM to EXEC.
  - EXEC: lasts exactly one cycle, with `rx_ready`=0. The result is computed and loaded into the TX shift register; `op_error` is registered here. Next state is SEND.
  - SEND: `rx_ready`=0 and `tx_valid`=1 for exactly DATA_WIDTH consecutive cycles, driving result bits LSB first. After the last bit the FSM returns to IDLE.
- Result rules:
  - ADD: (op_1 + op_2) mod 2^DATA_WIDTH; carry discarded.
  - AND: op_1 & op_2.
  - OR: op_1 | op_2.
  - MUL, SHL, SHR, LW, SW: result 0 and `op_error`=1. These belong to other units.
- `rx_valid` while `rx_ready`=0 is ignored. No bit is consumed or buffered.
- Reset behaviour:
  - Reset values: `rx_ready`=1, `tx_valid`=0, `tx_data`=0, `op_error`=0, FSM=IDLE, counters and shift registers zero.
  - Reset asserted mid-RECV or mid-SEND aborts immediately. The partial packet is discarded, and no further `tx_valid` follows until a new full packet arrives.

## Timing
- Input side: one bit per accepted cycle, so at least P cycles per packet.
- Latency: let edge E be the edge that accepts bit P−1. The cycle after E is EXEC. The first `tx_valid` cycle starts one edge later, i.e. the second cycle after E.
- `tx_data` and `tx_valid` are registered outputs. They change only on rising edges, except on reset assertion.
- Back-to-back throughput is P + 1 + DATA_WIDTH cycles per packet (100 at defaults). `rx_ready` rises in the first cycle after the last SEND cycle.

## Configuration
- Macro: `ALU_SERIAL_RESPONDER_PARITY_EN`.
- Defined:
  - SEND lasts DATA_WIDTH+1 cycles.
  - The extra final bit is the even parity of the result: XOR of all result bits, and of `op_error`.
  - Back-to-back throughput grows by 1 cycle.
- Undefined: SEND lasts exactly DATA_WIDTH cycles and no parity logic is present.

## Test plan
- **ADD with wrap:** op=ADD, op_1=0xFFFFFFFF, op_2=0x00000001, sent with `rx_valid` continuous.
  - Result 0x00000000, `op_error`=0.
  - First `tx_valid` exactly 2 cycles after the accepting edge of bit 66.
  - `tx_valid` high for 32 cycles (33 with PARITY_EN, parity bit 0).
- **AND with gaps:** op=AND, op_1=0xF0F0F0F0, op_2=0xFF00FF00, with `rx_valid` low every third cycle.
  - Result 0xF000F000, `op_error`=0.
- **OR, back-to-back:** op=OR, op_1=0x12340000, op_2=0x00005678 gives 0x12345678.
  - A second packet offered during SEND is not accepted (`rx_ready`=0).
  - That packet is accepted once `rx_ready` returns to 1 and its result is correct.
- **Unsupported op:** op=MUL (3), op_1=5, op_2=7.
  - 32 zero result bits with `op_error`=1 throughout SEND.
  - With PARITY_EN, the parity bit is 1.
- **Reset mid-operation:** assert `reset` after bit 40 of a packet, then send a fresh ADD 2+3.
  - Outputs return to reset values immediately.
  - The fresh packet returns 0x00000005 with no residue from the aborted packet.
- **Reset during SEND:** assert `reset` at SEND bit 10.
  - `tx_valid` drops asynchronously and the FSM is in IDLE after release.

Source files
------------

// File: rtl/alu_serial_responder.sv
// alu_serial_responder
//   Bit-serial ALU end of the processor-to-ALU link. Shifts in one packet
//   (op_code, op_1, op_2, each LSB first), executes ADD/AND/OR and shifts the
//   DATA_WIDTH-bit result back out LSB first. Any other op_code yields a zero
//   result with op_error set.
//
//   Ports:
//     clock     in   rising-edge clock
//     reset     in   asynchronous active-high reset
//     rx_data   in   incoming packet bit
//     rx_valid  in   rx_data valid this cycle
//     rx_ready  out  a bit is accepted this cycle when rx_valid is also high
//     tx_data   out  outgoing result bit (registered)
//     tx_valid  out  tx_data valid this cycle, no backpressure (registered)
//     op_error  out  current result is from an unsupported op_code
//
//   Optional feature macro: ALU_SERIAL_RESPONDER_PARITY_EN
//     When defined, one extra bit follows the result: the XOR of all result
//     bits and op_error.
module alu_serial_responder #(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic rx_data,
  input  logic rx_valid,
  output logic rx_ready,
  output logic tx_data,
  output logic tx_valid,
  output logic op_error
);

  localparam int PKT_LEN = OPCODE_WIDTH + 2 * DATA_WIDTH;
  localparam int CNT_W   = $clog2(PKT_LEN);
`ifdef ALU_SERIAL_RESPONDER_PARITY_EN
  localparam int SEND_LEN = DATA_WIDTH + 1;
`else
  localparam int SEND_LEN = DATA_WIDTH;
`endif
  localparam int SEND_W = $clog2(SEND_LEN);

  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(PKT_LEN - 1);
  localparam logic [SEND_W-1:0] LAST_SEND = SEND_W'(SEND_LEN - 1);

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR  = OPCODE_WIDTH'(2);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    EXEC,
    SEND
  } state_t;

  state_t                  state;
  logic [PKT_LEN-1:0]      pkt_q;
  logic [CNT_W-1:0]        bit_cnt;
  logic [SEND_W-1:0]       send_cnt;
  logic [SEND_LEN-1:0]     tx_shift;

  logic [OPCODE_WIDTH-1:0] op_field;
  logic [DATA_WIDTH-1:0]   op_1;
  logic [DATA_WIDTH-1:0]   op_2;
  logic [DATA_WIDTH-1:0]   result;
  logic                    result_err;
  logic [SEND_LEN-1:0]     payload;
  logic                    accept;

  assign accept = rx_valid && rx_ready;

  // Bits enter at the MSB end, so after a full packet the first bit received
  // (op_code LSB) sits at bit 0 and older packets are shifted out entirely.
  assign op_field = pkt_q[OPCODE_WIDTH-1:0];
  assign op_1     = pkt_q[OPCODE_WIDTH +: DATA_WIDTH];
  assign op_2     = pkt_q[OPCODE_WIDTH + DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    result     = '0;
    result_err = 1'b0;
    case (op_field)
      OP_ADD:  result = op_1 + op_2;
      OP_AND:  result = op_1 & op_2;
      OP_OR:   result = op_1 | op_2;
      default: result_err = 1'b1;
    endcase
  end

`ifdef ALU_SERIAL_RESPONDER_PARITY_EN
  assign payload = {(^result) ^ result_err, result};
`else
  assign payload = result;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rx_ready <= 1'b1;
      tx_valid <= 1'b0;
      tx_data  <= 1'b0;
      op_error <= 1'b0;
      pkt_q    <= '0;
      bit_cnt  <= '0;
      send_cnt <= '0;
      tx_shift <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pkt_q   <= {rx_data, pkt_q[PKT_LEN-1:1]};
            bit_cnt <= CNT_W'(1);
            state   <= RECV;
          end
        end
        RECV: begin
          if (accept) begin
            pkt_q <= {rx_data, pkt_q[PKT_LEN-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt  <= '0;
              rx_ready <= 1'b0;
              state    <= EXEC;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        EXEC: begin
          // First output bit goes straight to tx_data; the rest wait in tx_shift.
          tx_data  <= payload[0];
          tx_shift <= payload >> 1;
          tx_valid <= 1'b1;
          op_error <= result_err;
          send_cnt <= '0;
          state    <= SEND;
        end
        SEND: begin
          if (send_cnt == LAST_SEND) begin
            tx_valid <= 1'b0;
            tx_data  <= 1'b0;
            op_error <= 1'b0;
            rx_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            tx_data  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            send_cnt <= send_cnt + SEND_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_responder.sv
// tb_alu_serial_responder
//   Randomized scoreboard bench for alu_serial_responder. The driver pushes
//   the expected response for every complete packet; an independent monitor
//   collects tx bits and compares.
module tb_alu_serial_responder;

  localparam int DW  = 32;
  localparam int OW  = 3;
  localparam int P   = OW + 2 * DW;
`ifdef ALU_SERIAL_RESPONDER_PARITY_EN
  localparam int SEND_LEN = DW + 1;
`else
  localparam int SEND_LEN = DW;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rx_data = 1'b0;
  logic rx_valid = 1'b0;
  logic rx_ready, tx_data, tx_valid, op_error;

  alu_serial_responder #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW)) dut (
    .clock    (clock),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .op_error (op_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  typedef struct {
    logic [DW-1:0] res;
    logic          err;
    logic          par;
    int            e_cyc;
  } exp_t;

  exp_t q[$];

  // Reference model straight from the operation table.
  function automatic exp_t model(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    longint unsigned s;
    e.err = 1'b0;
    case (op)
      3'd0: begin s = (longint'(a) + longint'(b)) % (64'd1 << DW); e.res = s[DW-1:0]; end
      3'd1: e.res = a & b;
      3'd2: e.res = a | b;
      default: begin e.res = '0; e.err = 1'b1; end
    endcase
    e.par = 1'b0;
    for (int i = 0; i < DW; i++) e.par = e.par ^ e.res[i];
    e.par = e.par ^ e.err;
    e.e_cyc = 0;
    return e;
  endfunction

  // gap_mode: 0 continuous, 1 rx_valid low every third cycle, 2 random gaps.
  // nbits < P sends only a partial packet (nothing is expected from it).
  task automatic send_packet(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input int gap_mode, input int nbits, output int stall);
    logic [P-1:0] pkt;
    int i, k, guard;
    logic ready_s;
    exp_t e;
    pkt = {b, a, op};
    i = 0; k = 0; guard = 0; stall = 0;
    while (i < nbits) begin
      @(negedge clock);
      guard++;
      if (guard > 3000) begin
        check("driver_timeout", 64'(i), 64'(nbits));
        rx_valid = 1'b0;
        break;
      end
      ready_s = rx_ready;
      if ((gap_mode == 1 && (k % 3) == 2) || (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
        rx_valid = 1'b0;
      end else begin
        rx_valid = 1'b1;
        rx_data  = pkt[i];
      end
      k++;
      if (!ready_s && i == 0) stall++;
      @(posedge clock);
      if (rx_valid && ready_s) begin
        i++;
        if (i == P) begin
          #1;
          e = model(op, a, b);
          e.e_cyc = cyc;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clock);
    rx_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  // Monitor
  int            mon_bits = 0;
  logic [SEND_LEN-1:0] got_bits;
  exp_t          cur;
  logic          err_ok, rdy_ok;

  always @(negedge clock) begin
    if (reset) begin
      mon_bits = 0;
      q.delete();
    end else if (tx_valid) begin
      if (mon_bits == 0) begin
        if (q.size() == 0) begin
          check("unexpected_tx_valid", 64'd1, 64'd0);
          cur.res = '0; cur.err = 1'b0; cur.par = 1'b0; cur.e_cyc = cyc - 1;
        end else begin
          cur = q.pop_front();
        end
        check("latency", 64'(cyc), 64'(cur.e_cyc + 1));
        err_ok = 1'b1;
        rdy_ok = 1'b1;
      end
      got_bits[mon_bits] = tx_data;
      if (op_error !== cur.err) err_ok = 1'b0;
      if (rx_ready !== 1'b0) rdy_ok = 1'b0;
      mon_bits++;
      if (mon_bits == SEND_LEN) begin
        check("result", 64'(got_bits[DW-1:0]), 64'(cur.res));
        check("op_error_steady", 64'(err_ok), 64'(1'b1));
        check("op_error_value", 64'(op_error), 64'(cur.err));
        check("rx_ready_low_in_send", 64'(rdy_ok), 64'(1'b1));
`ifdef ALU_SERIAL_RESPONDER_PARITY_EN
        check("parity", 64'(got_bits[SEND_LEN-1]), 64'(cur.par));
`endif
        mon_bits = 0;
      end
    end else if (mon_bits != 0) begin
      check("tx_valid_length", 64'(mon_bits), 64'(SEND_LEN));
      mon_bits = 0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 64'(rx_ready), 64'(1'b1));
    check({tag, "_tx_valid"}, 64'(tx_valid), 64'(1'b0));
    check({tag, "_tx_data"},  64'(tx_data),  64'(1'b0));
    check({tag, "_op_error"}, 64'(op_error), 64'(1'b0));
  endtask

  initial begin
    int stall, guard, seen;
    logic [2:0] op;
    logic [DW-1:0] a, b;

    #12;
    check_reset_outputs("por");
    @(negedge clock); #1 reset = 1'b0;

    // ADD with wrap, continuous
    send_packet(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0, P, stall);
    idle(40);

    // AND with gaps every third cycle
    send_packet(3'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, P, stall);
    idle(40);

    // OR then a second packet offered during SEND
    send_packet(3'd2, 32'h1234_0000, 32'h0000_5678, 0, P, stall);
    send_packet(3'd1, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 0, P, stall);
    check("b2b_stall_cycles", 64'(stall), 64'(1 + SEND_LEN));
    idle(40);

    // Unsupported op MUL
    send_packet(3'd3, 32'd5, 32'd7, 0, P, stall);
    idle(40);

    // Reset mid-RECV after bit 40
    send_packet(3'd2, 32'hAAAA_5555, 32'h1234_5678, 0, 41, stall);
    @(negedge clock);
    rx_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_recv");
    @(negedge clock); @(negedge clock); #1 reset = 1'b0;
    send_packet(3'd0, 32'd2, 32'd3, 0, P, stall);
    idle(40);

    // Reset during SEND bit 10
    send_packet(3'd1, 32'hFFFF_0000, 32'hFF00_FF00, 0, P, stall);
    rx_valid = 1'b0;
    repeat (11) @(posedge clock);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_send");
    @(negedge clock); @(negedge clock); #1 reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (tx_valid) seen++;
    end
    check("no_tx_after_send_abort", 64'(seen), 64'd0);
    check("idle_after_send_abort", 64'(rx_ready), 64'(1'b1));

    // Randomized packets
    for (int n = 0; n < 24; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom();
      b  = $urandom();
      if ($urandom_range(0, 5) == 0) a = '1;
      if ($urandom_range(0, 5) == 0) b = 32'd1;
      send_packet(op, a, b, ($urandom_range(0, 1) == 0) ? 0 : 2, P, stall);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 5));
    end

    guard = 0;
    while ((q.size() != 0 || mon_bits != 0) && guard < 2000) begin
      @(negedge clock);
      guard++;
    end
    check("scoreboard_drained", 64'(q.size() + mon_bits), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
